clint_timer: RTL and testbench

CLINT_TIMER -- requirements
Module: clint_timer

---
 rtl/clint_timer.sv | 114 +++++++++++
 tb/tb_clint_timer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/clint_timer.sv
// RISC-V CLINT-style machine timer: free-running mtime with prescaler, mtimecmp compare
// and MSIP software interrupt, behind a single-outstanding request/ack register bus.
module clint_timer #(
   parameter int unsigned REG_WIDTH = 64,
   parameter int unsigned TICK_DIV  = 1
) (
   input  logic                 clk_sys_i,
   input  logic                 rst_i,
   input  logic                 bus_req_i,
   input  logic                 bus_we_i,
   input  logic [15:0]          bus_addr_i,
   input  logic [REG_WIDTH-1:0] bus_wdata_i,
   output logic                 bus_ack_o,
   output logic [REG_WIDTH-1:0] bus_rdata_o,
   output logic                 bus_err_o,
   output logic                 time_intr_o,
   output logic                 software_intr_o,
   output logic [REG_WIDTH-1:0] mtime_o
);

   localparam logic [15:0] ADDR_MSIP     = 16'h0000;
   localparam logic [15:0] ADDR_MTIMECMP = 16'h4000;
   localparam logic [15:0] ADDR_MTIME    = 16'hBFF8;
   localparam logic [15:0] PRESC_MAX     = 16'(TICK_DIV - 1);

   logic [15:0]          presc_q, presc_d;
   logic [REG_WIDTH-1:0] mtime_q, mtime_d;
   logic [REG_WIDTH-1:0] mtimecmp_q, mtimecmp_d;
   logic                 msip_q, msip_d;
   logic                 ack_q, ack_d;
   logic                 err_q, err_d;
   logic [REG_WIDTH-1:0] rdata_q, rdata_d;
   logic                 intr_q, intr_d;

   logic accept, wr, rd, tick;
   logic sel_msip, sel_cmp, sel_mtime, unmapped;

   always_comb begin
      // A request is only taken while no ack is showing, giving one access per two cycles.
      accept    = bus_req_i & ~ack_q;
      wr        = accept & bus_we_i;
      rd        = accept & ~bus_we_i;
      sel_msip  = (bus_addr_i == ADDR_MSIP);
      sel_cmp   = (bus_addr_i == ADDR_MTIMECMP);
      sel_mtime = (bus_addr_i == ADDR_MTIME);
      unmapped  = ~(sel_msip | sel_cmp | sel_mtime);
      tick      = (presc_q == PRESC_MAX);

      presc_d = tick ? 16'd0 : presc_q + 16'd1;

      // A software write to mtime wins over a coincident tick.
      mtime_d = mtime_q;
      if (wr && sel_mtime) begin
         mtime_d = bus_wdata_i;
      end else if (tick) begin
         mtime_d = mtime_q + REG_WIDTH'(1);
      end

      mtimecmp_d = mtimecmp_q;
      if (wr && sel_cmp) begin
         mtimecmp_d = bus_wdata_i;
      end

      msip_d = msip_q;
      if (wr && sel_msip) begin
         msip_d = bus_wdata_i[0];
      end

      rdata_d = '0;
      if (rd) begin
         if (sel_msip) begin
            rdata_d = {{(REG_WIDTH-1){1'b0}}, msip_q};
         end else if (sel_cmp) begin
            rdata_d = mtimecmp_q;
         end else if (sel_mtime) begin
            rdata_d = mtime_q;
         end
      end

      ack_d  = accept;
      err_d  = accept & unmapped;
      intr_d = (mtime_q >= mtimecmp_q);
   end

   always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
         presc_q    <= '0;
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         msip_q     <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         intr_q     <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         msip_q     <= msip_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
         intr_q     <= intr_d;
      end
   end

   assign bus_ack_o       = ack_q;
   assign bus_err_o       = err_q;
   assign bus_rdata_o     = rdata_q;
   assign time_intr_o     = intr_q;
   assign software_intr_o = msip_q;
   assign mtime_o         = mtime_q;

endmodule

// File: tb/tb_clint_timer.sv
// Testbench for clint_timer: two instances (TICK_DIV=1 and 4) share one bus and are
// compared every cycle against a behavioural model, plus directed scenario checks.
module tb_clint_timer;

   localparam int W = 64;
   localparam logic [15:0] A_MSIP = 16'h0000;
   localparam logic [15:0] A_CMP  = 16'h4000;
   localparam logic [15:0] A_TIME = 16'hBFF8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, req, we;
   logic [15:0]   addr;
   logic [W-1:0]  wdata;
   logic          ack [2];
   logic          err [2];
   logic          ti  [2];
   logic          si  [2];
   logic [W-1:0]  rdata [2];
   logic [W-1:0]  mtime [2];

   clint_timer #(.REG_WIDTH(W), .TICK_DIV(1)) u_dut1 (
      .clk_sys_i(clk), .rst_i(rst), .bus_req_i(req), .bus_we_i(we),
      .bus_addr_i(addr), .bus_wdata_i(wdata), .bus_ack_o(ack[0]),
      .bus_rdata_o(rdata[0]), .bus_err_o(err[0]), .time_intr_o(ti[0]),
      .software_intr_o(si[0]), .mtime_o(mtime[0])
   );

   clint_timer #(.REG_WIDTH(W), .TICK_DIV(4)) u_dut4 (
      .clk_sys_i(clk), .rst_i(rst), .bus_req_i(req), .bus_we_i(we),
      .bus_addr_i(addr), .bus_wdata_i(wdata), .bus_ack_o(ack[1]),
      .bus_rdata_o(rdata[1]), .bus_err_o(err[1]), .time_intr_o(ti[1]),
      .software_intr_o(si[1]), .mtime_o(mtime[1])
   );

   int checks = 0;
   int errors = 0;

   // Behavioural model state, one slot per instance.
   int unsigned  m_div [2] = '{1, 4};
   longint unsigned m_edges [2];
   logic [W-1:0] m_mtime [2];
   logic [W-1:0] m_cmp   [2];
   logic         m_msip  [2];
   logic         m_ack   [2];
   logic         m_err   [2];
   logic [W-1:0] m_rdata [2];
   logic         m_intr  [2];

   task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input int k, input bit r, input bit q, input bit w,
                             input logic [15:0] a, input logic [W-1:0] d);
      bit acc, tick, mapped;
      logic [W-1:0] val;
      if (r) begin
         m_edges[k] = 0; m_mtime[k] = '0; m_cmp[k] = '1; m_msip[k] = 1'b0;
         m_ack[k] = 1'b0; m_err[k] = 1'b0; m_rdata[k] = '0; m_intr[k] = 1'b0;
         return;
      end
      acc    = q && !m_ack[k];
      mapped = (a == A_MSIP) || (a == A_CMP) || (a == A_TIME);
      val    = (a == A_MSIP) ? W'(m_msip[k]) : (a == A_CMP) ? m_cmp[k] :
               (a == A_TIME) ? m_mtime[k] : '0;
      m_intr[k] = (m_mtime[k] >= m_cmp[k]);
      // Every TICK_DIV-th edge since reset is a tick.
      tick = ((m_edges[k] % m_div[k]) == m_div[k] - 1);
      m_edges[k]++;
      if (acc && w && a == A_TIME) m_mtime[k] = d;
      else if (tick)               m_mtime[k] = m_mtime[k] + 1;
      if (acc && w && a == A_CMP)  m_cmp[k]  = d;
      if (acc && w && a == A_MSIP) m_msip[k] = d[0];
      m_ack[k]   = acc;
      m_err[k]   = acc && !mapped;
      m_rdata[k] = (acc && !w) ? val : '0;
      if (k == 0 && acc)
         $display("txn %s addr=%h wdata=%h", w ? "WR" : "RD", a, d);
   endtask

   task automatic cyc(input bit r, input bit q, input bit w,
                      input logic [15:0] a, input logic [W-1:0] d);
      rst = r; req = q; we = w; addr = a; wdata = d;
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k, r, q, w, a, d);
      #1;
      for (int k = 0; k < 2; k++) begin
         check_val($sformatf("ack%0d", k),   W'(ack[k]), W'(m_ack[k]));
         check_val($sformatf("err%0d", k),   W'(err[k]), W'(m_err[k]));
         check_val($sformatf("rdata%0d", k), rdata[k],   m_rdata[k]);
         check_val($sformatf("tintr%0d", k), W'(ti[k]),  W'(m_intr[k]));
         check_val($sformatf("sintr%0d", k), W'(si[k]),  W'(m_msip[k]));
         check_val($sformatf("mtime%0d", k), mtime[k],   m_mtime[k]);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0, '0);
   endtask

   initial begin
      int t20, tint, nack;
      logic [W-1:0] d;
      logic [15:0] a;
      int sel;

      rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;

      // Reset state and prescaled count with TICK_DIV=4.
      cyc(1'b1, 1'b0, 1'b0, 16'h0, '0);
      check_val("rst_ack", W'(ack[0]), '0);
      check_val("rst_mtime", mtime[1], '0);
      for (int i = 0; i < 40; i++) begin
         idle(1);
         check_val("div4_no_intr", W'(ti[1]), '0);
      end
      check_val("div4_mtime40", mtime[1], W'(10));

      // Compare match timing with TICK_DIV=1.
      cyc(1'b1, 1'b0, 1'b0, 16'h0, '0);
      idle(5);
      check_val("mtime_at5", mtime[0], W'(5));
      cyc(1'b0, 1'b1, 1'b1, A_CMP, W'(20));
      t20 = -1; tint = -1;
      for (int i = 0; i < 30; i++) begin
         idle(1);
         if (mtime[0] == W'(20) && t20 < 0) t20 = i;
         if (ti[0] && tint < 0) tint = i;
      end
      check_val("intr_rise_lag", W'(tint - t20), W'(1));
      cyc(1'b0, 1'b1, 1'b1, A_CMP, W'(1000));
      check_val("intr_after_wr", W'(ti[0]), W'(1));
      idle(1);
      check_val("intr_fall", W'(ti[0]), W'(0));

      // Software interrupt.
      cyc(1'b0, 1'b1, 1'b1, A_MSIP, W'(16'hFFFF));
      check_val("msip_set", W'(si[0]), W'(1));
      idle(1);
      cyc(1'b0, 1'b1, 1'b0, A_MSIP, '0);
      check_val("msip_read", rdata[0], W'(1));
      idle(1);
      cyc(1'b0, 1'b1, 1'b1, A_MSIP, '0);
      check_val("msip_clr", W'(si[0]), W'(0));
      idle(1);

      // mtime wrap, write coinciding with a tick.
      cyc(1'b0, 1'b1, 1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE);
      check_val("mtime_wr_exact", mtime[0], 64'hFFFF_FFFF_FFFF_FFFE);
      check_val("mtime_wr_noerr", W'(err[0]), '0);
      idle(2);
      check_val("mtime_wrap", mtime[0], '0);

      // Unmapped access and held request throughput.
      cyc(1'b0, 1'b1, 1'b0, 16'h1234, '0);
      check_val("unmap_ack", W'(ack[0]), W'(1));
      check_val("unmap_err", W'(err[0]), W'(1));
      check_val("unmap_rdata", rdata[0], '0);
      idle(1);
      check_val("unmap_ack_1cyc", W'(ack[0]), '0);
      nack = 0;
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, 1'b1, 1'b0, A_MSIP, '0);
         if (ack[0]) nack++;
      end
      check_val("held_req_acks", W'(nack), W'(3));
      idle(1);

      // Reset beats an in-flight write.
      cyc(1'b1, 1'b1, 1'b1, A_CMP, '0);
      check_val("rst_drop_ack", W'(ack[0]), '0);
      check_val("rst_drop_intr", W'(ti[0]), '0);
      cyc(1'b0, 1'b1, 1'b0, A_CMP, '0);
      check_val("rst_cmp_ones", rdata[0], '1);
      idle(3);
      check_val("rst_no_intr", W'(ti[0]), '0);

      // Randomised traffic against the model.
      for (int i = 0; i < 400; i++) begin
         sel = $urandom_range(0, 4);
         case (sel)
            0: a = A_MSIP;
            1, 2: a = A_CMP;
            3: a = A_TIME;
            default: a = 16'($urandom);
         endcase
         if ($urandom_range(0, 1) == 1)
            d = {$urandom, $urandom};
         else
            d = m_mtime[$urandom_range(0, 1)] + W'($urandom_range(0, 12)) - W'(6);
         cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1),
             ($urandom_range(0, 1) == 1), a, d);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
